i2c_cfg_arbiter: RTL and testbench
==================================

// Module: i2c_cfg_arbiter
// PURPOSE
//   Shares one I2C byte-write engine (slave addr + 8-bit reg addr + 8-bit data, one transaction
//   per command) between NUM_REQ configuration requesters, e.g. ADC setup and DAC/PGA setup.
//   Round-robin grants, command latching, valid/ready issue, done/NACK return per requester.
//   Sits between the config sequencers and the I2C bit engine, all in the sys_clk domain.
// PARAMETERS
//   NUM_REQ         2        number of requesters, legal range 1..8
//   TIMEOUT_CYCLES  100000   sys_clk cycles allowed for ISSUE+WAIT (used only with timeout macro)
// PORTS
//   sys_clk         in   1          system clock, all logic on rising edge
//   rst             in   1          asynchronous reset, active-high
//   req             in   NUM_REQ    level request per requester
//   req_slave_addr  in   7*NUM_REQ  7-bit slave address, requester i at [7i+6:7i]
//   req_reg_addr    in   8*NUM_REQ  register address, requester i at [8i+7:8i]
//   req_data        in   8*NUM_REQ  write data, requester i at [8i+7:8i]
//   gnt             out  NUM_REQ    one-cycle pulse: fields of requester i captured
//   rsp_done        out  NUM_REQ    one-cycle pulse: transaction of requester i finished
//   rsp_nack        out  NUM_REQ    valid with rsp_done: 1 = slave did not ACK
//   rsp_err         out  NUM_REQ    valid with rsp_done: 1 = timeout abort
//   eng_cmd_valid   out  1          command valid to engine
//   eng_cmd_ready   in   1          engine accepts command
//   eng_slave_addr  out  7          latched slave address
//   eng_reg_addr    out  8          latched register address
//   eng_data        out  8          latched write data
//   eng_done        in   1          engine one-cycle pulse: transaction complete (incl. STOP)
//   eng_ack         in   1          valid with eng_done: 1 = all three bytes ACKed
//   eng_abort       out  1          one-cycle pulse: engine must drop to idle and issue STOP
//   busy            out  1          1 whenever state != IDLE
// BEHAVIOUR
//   Reset: all outputs 0, eng_* fields 0, state IDLE, rr pointer 0. Async reset mid-transaction
//     drops eng_cmd_valid at once; no rsp_done is issued for the killed transaction.
//   FSM: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
//   IDLE: if |req, select first asserted index scanning ptr, ptr+1, ... (mod NUM_REQ). On that
//     edge: gnt[i]<=1, latch fields of i into eng_*, eng_cmd_valid<=1, state<=ISSUE. gnt is
//     low again on the next edge. Latency req-seen -> gnt/eng_cmd_valid high: 1 cycle.
//   ISSUE: eng_cmd_valid held, fields stable until the cycle eng_cmd_ready=1; on that edge
//     eng_cmd_valid<=0, state<=WAIT. eng_done in ISSUE is ignored.
//   WAIT: on eng_done capture eng_ack, state<=RESP. eng_cmd_ready in WAIT is ignored.
//   RESP (1 cycle): rsp_done[i]=1, rsp_nack[i]=~ack, rsp_err[i]=0; ptr<=(i+1) mod NUM_REQ
//     (wraps NUM_REQ-1 -> 0); state<=IDLE. Outputs for other indices stay 0.
//   Requester protocol: hold req and fields until gnt; deassert req the cycle after gnt unless
//     a further transaction is wanted. req still high in IDLE after RESP = new transaction.
//   Requests arriving while busy wait; no queueing beyond the req level. NUM_REQ=1: ptr fixed 0.
//   Min back-to-back spacing: one IDLE cycle between RESP and next gnt.
// CONFIGURATION
//   I2C_ARB_TIMEOUT_EN defined: cycle counter cleared on entry to ISSUE, counts in ISSUE and WAIT;
//     on reaching TIMEOUT_CYCLES-1 without completion: eng_cmd_valid<=0, eng_abort pulses 1
//     cycle, state<=RESP with rsp_err[i]=1, rsp_nack[i]=0. eng_done on the expiry edge wins
//     (normal completion, no abort).
//   Not defined: no counter; rsp_err and eng_abort tied 0; WAIT lasts until eng_done.
// TESTING
//   1 req=2'b01, slave 7'h40, reg 8'h1D, data 8'h00; ready at 3rd ISSUE cycle, done+ack=1 ->
//     gnt=01 one cycle, eng fields 40/1D/00 stable to handshake, rsp_done=01, rsp_nack=0.
//   2 req=2'b11 held continuously, ptr 0 -> grants alternate 0,1,0,1; each rsp_done precedes
//     next gnt by exactly 2 cycles (RESP + IDLE).
//   3 NUM_REQ=3, only req[2] high repeatedly -> served each time, ptr wraps 2 -> 0.
//   4 eng_done with eng_ack=0 for req 1 -> rsp_done=10, rsp_nack=10, ptr advances.
//   5 rst high during WAIT -> next cycle all outputs 0, no rsp_done; after release req 1 served
//     first only if req 0 low (ptr 0).
//   6 I2C_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, eng_done never -> eng_abort pulse 16 cycles after
//     ISSUE entry, rsp_err=01, rsp_nack=0; without macro busy stays 1.

Source files
------------

// File: rtl/i2c_cfg_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : i2c_cfg_arbiter
// Purpose  : Round-robin arbiter sharing one I2C byte-write engine between
//            NUM_REQ configuration requesters (latch, issue, done/NACK return).
// Options  : define I2C_ARB_TIMEOUT_EN to abort ISSUE+WAIT after TIMEOUT_CYCLES.
// Revision : 1.0 - initial release
// ============================================================================
module i2c_cfg_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                   sys_clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [7*NUM_REQ-1:0]   req_slave_addr,
    input  logic [8*NUM_REQ-1:0]   req_reg_addr,
    input  logic [8*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]     gnt,
    output logic [NUM_REQ-1:0]     rsp_done,
    output logic [NUM_REQ-1:0]     rsp_nack,
    output logic [NUM_REQ-1:0]     rsp_err,
    output logic                   eng_cmd_valid,
    input  logic                   eng_cmd_ready,
    output logic [6:0]             eng_slave_addr,
    output logic [7:0]             eng_reg_addr,
    output logic [7:0]             eng_data,
    input  logic                   eng_done,
    input  logic                   eng_ack,
    output logic                   eng_abort,
    output logic                   busy
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;

    logic [PW-1:0]        r_ptr;
    logic [PW-1:0]        r_idx;
    logic [NUM_REQ-1:0]   r_own;
    logic [NUM_REQ-1:0]   r_gnt;
    logic                 r_valid;
    logic [6:0]           r_sa;
    logic [7:0]           r_ra;
    logic [7:0]           r_da;
    logic                 r_ack;

    logic                 w_sel_vld;
    logic [PW-1:0]        w_sel_idx;
    logic [NUM_REQ-1:0]   w_sel_oh;
    logic [6:0]           w_sel_sa;
    logic [7:0]           w_sel_ra;
    logic [7:0]           w_sel_da;
    logic                 w_expire;
    logic                 w_tmo_flag;
    logic [NUM_REQ-1:0]   w_resp_mask;

    // Scan ptr, ptr+1, ... ; iterating downwards lets the lowest offset win.
    always_comb begin : p_select
        int j;
        j         = 0;
        w_sel_vld = 1'b0;
        w_sel_idx = '0;
        w_sel_oh  = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            j = int'(r_ptr) + k;
            if (j >= NUM_REQ) begin
                j = j - NUM_REQ;
            end
            if (req[j]) begin
                w_sel_vld   = 1'b1;
                w_sel_idx   = PW'(j);
                w_sel_oh    = '0;
                w_sel_oh[j] = 1'b1;
            end
        end
    end

    always_comb begin : p_fields
        w_sel_sa = '0;
        w_sel_ra = '0;
        w_sel_da = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (w_sel_oh[k]) begin
                w_sel_sa = req_slave_addr[7*k +: 7];
                w_sel_ra = req_reg_addr[8*k +: 8];
                w_sel_da = req_data[8*k +: 8];
            end
        end
    end

`ifdef I2C_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

    logic [TW-1:0] r_tcnt;
    logic          r_tmo;
    logic          r_abort;
    logic          w_active;

    assign w_active = (r_state == S_ISSUE) || (r_state == S_WAIT);
    // A completion on the expiry edge takes priority over the abort.
    assign w_expire = w_active && (r_tcnt == TW'(TIMEOUT_CYCLES - 1)) &&
                      !((r_state == S_WAIT) && eng_done);

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            r_tcnt  <= '0;
            r_tmo   <= 1'b0;
            r_abort <= 1'b0;
        end else begin
            r_abort <= w_expire;
            if (w_active) begin
                r_tcnt <= r_tcnt + 1'b1;
            end else begin
                r_tcnt <= '0;
            end
            if (w_expire) begin
                r_tmo <= 1'b1;
            end else if (r_state == S_IDLE) begin
                r_tmo <= 1'b0;
            end
        end
    end

    assign w_tmo_flag = r_tmo;
    assign eng_abort  = r_abort;
`else
    logic w_unused_timeout_cfg;
    assign w_unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
    assign w_expire   = 1'b0;
    assign w_tmo_flag = 1'b0;
    assign eng_abort  = 1'b0;
`endif

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_sel_vld) begin
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (w_expire) begin
                    w_state_nxt = S_RESP;
                end else if (eng_cmd_ready) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (eng_done || w_expire) begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            r_gnt   <= '0;
            r_own   <= '0;
            r_idx   <= '0;
            r_ptr   <= '0;
            r_valid <= 1'b0;
            r_sa    <= '0;
            r_ra    <= '0;
            r_da    <= '0;
            r_ack   <= 1'b0;
        end else begin
            r_gnt <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_sel_vld) begin
                        r_gnt   <= w_sel_oh;
                        r_own   <= w_sel_oh;
                        r_idx   <= w_sel_idx;
                        r_valid <= 1'b1;
                        r_sa    <= w_sel_sa;
                        r_ra    <= w_sel_ra;
                        r_da    <= w_sel_da;
                        r_ack   <= 1'b0;
                    end
                end
                S_ISSUE: begin
                    if (w_expire || eng_cmd_ready) begin
                        r_valid <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (eng_done) begin
                        r_ack <= eng_ack;
                    end
                end
                S_RESP: begin
                    r_ptr <= (r_idx == PW'(NUM_REQ - 1)) ? '0 : r_idx + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign w_resp_mask    = (r_state == S_RESP) ? r_own : '0;
    assign rsp_done       = w_resp_mask;
    assign rsp_nack       = w_resp_mask & {NUM_REQ{~r_ack & ~w_tmo_flag}};
    assign rsp_err        = w_resp_mask & {NUM_REQ{w_tmo_flag}};
    assign gnt            = r_gnt;
    assign eng_cmd_valid  = r_valid;
    assign eng_slave_addr = r_sa;
    assign eng_reg_addr   = r_ra;
    assign eng_data       = r_da;
    assign busy           = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_i2c_cfg_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2c_cfg_arbiter
// Purpose  : Self-checking bench for i2c_cfg_arbiter (three requesters).
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2c_cfg_arbiter;

    localparam int N = 3;

    logic            sys_clk = 1'b0;
    logic            rst     = 1'b1;
    logic [N-1:0]    req     = '0;
    logic [7*N-1:0]  req_slave_addr = '0;
    logic [8*N-1:0]  req_reg_addr   = '0;
    logic [8*N-1:0]  req_data       = '0;
    logic [N-1:0]    gnt;
    logic [N-1:0]    rsp_done;
    logic [N-1:0]    rsp_nack;
    logic [N-1:0]    rsp_err;
    logic            eng_cmd_valid;
    logic            eng_cmd_ready = 1'b0;
    logic [6:0]      eng_slave_addr;
    logic [7:0]      eng_reg_addr;
    logic [7:0]      eng_data;
    logic            eng_done = 1'b0;
    logic            eng_ack  = 1'b0;
    logic            eng_abort;
    logic            busy;

    always #5 sys_clk = ~sys_clk;

    i2c_cfg_arbiter #(
        .NUM_REQ        (N),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .sys_clk        (sys_clk),
        .rst            (rst),
        .req            (req),
        .req_slave_addr (req_slave_addr),
        .req_reg_addr   (req_reg_addr),
        .req_data       (req_data),
        .gnt            (gnt),
        .rsp_done       (rsp_done),
        .rsp_nack       (rsp_nack),
        .rsp_err        (rsp_err),
        .eng_cmd_valid  (eng_cmd_valid),
        .eng_cmd_ready  (eng_cmd_ready),
        .eng_slave_addr (eng_slave_addr),
        .eng_reg_addr   (eng_reg_addr),
        .eng_data       (eng_data),
        .eng_done       (eng_done),
        .eng_ack        (eng_ack),
        .eng_abort      (eng_abort),
        .busy           (busy)
    );

    typedef struct packed {
        logic [2:0] gnt;
        logic [6:0] sa;
        logic [7:0] ra;
        logic [7:0] da;
    } gexp_t;

    typedef struct packed {
        logic [2:0] done;
        logic [2:0] nack;
        logic [2:0] err;
    } rexp_t;

    gexp_t gq[$];
    rexp_t rq[$];
    gexp_t last_g = '0;
    gexp_t mon_g;
    rexp_t mon_r;
    int    n_checks = 0;
    int    n_err    = 0;

    // Grants and responses are checked against the queues as the DUT emits them.
    always @(negedge sys_clk) begin
        if (!rst) begin
            if (gnt !== 3'b000) begin
                n_checks++;
                if (gq.size() == 0) begin
                    n_err++;
                    $display("FAIL gnt_unexpected: gnt=%b, expected no grant", gnt);
                end else begin
                    mon_g  = gq.pop_front();
                    last_g = mon_g;
                    if ({gnt, eng_slave_addr, eng_reg_addr, eng_data, eng_cmd_valid} !==
                        {mon_g.gnt, mon_g.sa, mon_g.ra, mon_g.da, 1'b1}) begin
                        n_err++;
                        $display("FAIL gnt_fields: got gnt=%b %h/%h/%h v=%b, expected %b %h/%h/%h v=1",
                                 gnt, eng_slave_addr, eng_reg_addr, eng_data, eng_cmd_valid,
                                 mon_g.gnt, mon_g.sa, mon_g.ra, mon_g.da);
                    end
                end
            end
            if (eng_cmd_valid === 1'b1 && eng_cmd_ready === 1'b1) begin
                n_checks++;
                if ({eng_slave_addr, eng_reg_addr, eng_data} !== {last_g.sa, last_g.ra, last_g.da}) begin
                    n_err++;
                    $display("FAIL handshake_fields: got %h/%h/%h, expected %h/%h/%h",
                             eng_slave_addr, eng_reg_addr, eng_data, last_g.sa, last_g.ra, last_g.da);
                end
            end
            if (rsp_done !== 3'b000) begin
                n_checks++;
                if (rq.size() == 0) begin
                    n_err++;
                    $display("FAIL rsp_unexpected: rsp_done=%b, expected none", rsp_done);
                end else begin
                    mon_r = rq.pop_front();
                    if ({rsp_done, rsp_nack, rsp_err} !== {mon_r.done, mon_r.nack, mon_r.err}) begin
                        n_err++;
                        $display("FAIL rsp: got done=%b nack=%b err=%b, expected done=%b nack=%b err=%b",
                                 rsp_done, rsp_nack, rsp_err, mon_r.done, mon_r.nack, mon_r.err);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic set_fields(input int idx, input logic [6:0] sa, input logic [7:0] ra,
                              input logic [7:0] da);
        req_slave_addr[7*idx +: 7] = sa;
        req_reg_addr[8*idx +: 8]   = ra;
        req_data[8*idx +: 8]       = da;
    endtask

    task automatic expect_txn(input int idx, input logic nack, input logic err, input bit want_rsp);
        gexp_t g;
        rexp_t r;
        logic [2:0] oh;
        oh       = '0;
        oh[idx]  = 1'b1;
        g.gnt    = oh;
        g.sa     = req_slave_addr[7*idx +: 7];
        g.ra     = req_reg_addr[8*idx +: 8];
        g.da     = req_data[8*idx +: 8];
        gq.push_back(g);
        r.done   = oh;
        r.nack   = nack ? oh : 3'b000;
        r.err    = err ? oh : 3'b000;
        if (want_rsp) begin
            rq.push_back(r);
        end
    endtask

    // Engine side of one transaction; returns at the negedge of the RESP cycle.
    task automatic serve(input logic [2:0] drop, input int rdy_wait, input logic ack,
                         input int done_wait);
        int n;
        n = 0;
        while (eng_cmd_valid !== 1'b1 && n < 40) begin
            @(negedge sys_clk);
            n++;
        end
        n_checks++;
        if (eng_cmd_valid !== 1'b1) begin
            n_err++;
            $display("FAIL cmd_valid_wait: eng_cmd_valid=%b after %0d cycles, expected 1", eng_cmd_valid, n);
            return;
        end
        req = req & ~drop;
        repeat (rdy_wait) @(negedge sys_clk);
        eng_cmd_ready = 1'b1;
        @(negedge sys_clk);
        eng_cmd_ready = 1'b0;
        repeat (done_wait) @(negedge sys_clk);
        eng_done = 1'b1;
        eng_ack  = ack;
        @(negedge sys_clk);
        eng_done = 1'b0;
        eng_ack  = 1'b0;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        req = '0;
        repeat (2) @(negedge sys_clk);
        rst = 1'b0;
        @(negedge sys_clk);
    endtask

    task automatic test_reset();
        req = 3'b111;
        repeat (2) @(negedge sys_clk);
        n_checks++;
        if ({gnt, rsp_done, rsp_nack, rsp_err, eng_cmd_valid, eng_slave_addr, eng_reg_addr,
             eng_data, eng_abort, busy} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: gnt=%b done=%b valid=%b fields=%h/%h/%h busy=%b, expected all 0",
                     gnt, rsp_done, eng_cmd_valid, eng_slave_addr, eng_reg_addr, eng_data, busy);
        end
        req = '0;
        rst = 1'b0;
        @(negedge sys_clk);
    endtask

    task automatic test_single();
        set_fields(0, 7'h40, 8'h1D, 8'h00);
        set_fields(1, 7'h11, 8'hEE, 8'h99);
        set_fields(2, 7'h22, 8'hDD, 8'h88);
        req = 3'b001;
        expect_txn(0, 1'b0, 1'b0, 1'b1);
        @(negedge sys_clk);
        n_checks++;
        if (gnt !== 3'b001 || eng_cmd_valid !== 1'b1) begin
            n_err++;
            $display("FAIL single_latency: gnt=%b valid=%b, expected gnt=001 valid=1", gnt, eng_cmd_valid);
        end
        serve(3'b001, 2, 1'b1, 1);
        n_checks++;
        if (rsp_done !== 3'b001 || rsp_nack !== 3'b000) begin
            n_err++;
            $display("FAIL single_rsp: done=%b nack=%b, expected done=001 nack=000", rsp_done, rsp_nack);
        end
        @(negedge sys_clk);
    endtask

    task automatic test_nack();
        set_fields(0, 7'h31, 8'h02, 8'h7E);
        set_fields(1, 7'h5A, 8'h0F, 8'hC3);
        req = 3'b010;
        expect_txn(1, 1'b1, 1'b0, 1'b1);
        serve(3'b010, 1, 1'b0, 2);
        n_checks++;
        if (rsp_done !== 3'b010 || rsp_nack !== 3'b010) begin
            n_err++;
            $display("FAIL nack_rsp: done=%b nack=%b, expected done=010 nack=010", rsp_done, rsp_nack);
        end
        @(negedge sys_clk);
        req = 3'b011;
        expect_txn(0, 1'b0, 1'b0, 1'b1);
        serve(3'b011, 0, 1'b1, 1);
        @(negedge sys_clk);
    endtask

    task automatic test_wrap();
        set_fields(1, 7'h0C, 8'h44, 8'h55);
        set_fields(2, 7'h6B, 8'hA0, 8'h5F);
        req = 3'b100;
        for (int i = 0; i < 3; i++) begin
            expect_txn(2, 1'b0, 1'b0, 1'b1);
        end
        for (int i = 0; i < 3; i++) begin
            serve((i == 2) ? 3'b100 : 3'b000, 1, 1'b1, 0);
            @(negedge sys_clk);
        end
        req = 3'b110;
        expect_txn(1, 1'b0, 1'b0, 1'b1);
        serve(3'b110, 0, 1'b1, 0);
        @(negedge sys_clk);
    endtask

    task automatic test_back_to_back();
        logic [2:0] e;
        apply_reset();
        set_fields(0, 7'h11, 8'h22, 8'h33);
        set_fields(1, 7'h44, 8'h55, 8'h66);
        for (int i = 0; i < 4; i++) begin
            expect_txn(i % 2, 1'b0, 1'b0, 1'b1);
        end
        req = 3'b011;
        for (int i = 0; i < 4; i++) begin
            serve((i == 3) ? 3'b011 : 3'b000, 0, 1'b1, 1);
            e = (i % 2 == 0) ? 3'b001 : 3'b010;
            n_checks++;
            if (rsp_done !== e) begin
                n_err++;
                $display("FAIL b2b_done_%0d: rsp_done=%b, expected %b", i, rsp_done, e);
            end
            @(negedge sys_clk);
            n_checks++;
            if (gnt !== 3'b000 || busy !== 1'b0) begin
                n_err++;
                $display("FAIL b2b_idle_%0d: gnt=%b busy=%b, expected gnt=000 busy=0", i, gnt, busy);
            end
            if (i < 3) begin
                @(negedge sys_clk);
                e = (i % 2 == 0) ? 3'b010 : 3'b001;
                n_checks++;
                if (gnt !== e) begin
                    n_err++;
                    $display("FAIL b2b_gnt_%0d: gnt=%b, expected %b two cycles after rsp_done", i, gnt, e);
                end
            end
        end
        @(negedge sys_clk);
    endtask

    task automatic test_reset_mid();
        set_fields(0, 7'h12, 8'h34, 8'h56);
        set_fields(1, 7'h78, 8'h9A, 8'hBC);
        req = 3'b001;
        expect_txn(0, 1'b0, 1'b0, 1'b1);
        serve(3'b001, 0, 1'b1, 0);
        @(negedge sys_clk);
        req = 3'b010;
        expect_txn(1, 1'b0, 1'b0, 1'b0);
        @(negedge sys_clk);
        req = '0;
        eng_cmd_ready = 1'b1;
        @(negedge sys_clk);
        eng_cmd_ready = 1'b0;
        @(negedge sys_clk);
        rst = 1'b1;
        #1;
        n_checks++;
        if (busy !== 1'b0 || eng_cmd_valid !== 1'b0 || rsp_done !== 3'b000) begin
            n_err++;
            $display("FAIL rst_async: busy=%b valid=%b done=%b, expected 0/0/000", busy, eng_cmd_valid, rsp_done);
        end
        @(negedge sys_clk);
        n_checks++;
        if ({gnt, rsp_done, rsp_nack, rsp_err, eng_cmd_valid, eng_slave_addr, eng_reg_addr,
             eng_data, eng_abort, busy} !== '0) begin
            n_err++;
            $display("FAIL rst_mid_outputs: gnt=%b done=%b fields=%h/%h/%h busy=%b, expected all 0",
                     gnt, rsp_done, eng_slave_addr, eng_reg_addr, eng_data, busy);
        end
        rst = 1'b0;
        eng_done = 1'b1;
        eng_ack  = 1'b1;
        @(negedge sys_clk);
        eng_done = 1'b0;
        eng_ack  = 1'b0;
        req = 3'b011;
        expect_txn(0, 1'b0, 1'b0, 1'b1);
        serve(3'b011, 0, 1'b1, 0);
        @(negedge sys_clk);
    endtask

    task automatic test_timeout();
        int n;
        set_fields(0, 7'h2A, 8'h3B, 8'h4C);
        req = 3'b001;
`ifdef I2C_ARB_TIMEOUT_EN
        expect_txn(0, 1'b0, 1'b1, 1'b1);
`else
        expect_txn(0, 1'b0, 1'b0, 1'b1);
`endif
        n = 0;
        while (eng_cmd_valid !== 1'b1 && n < 40) begin
            @(negedge sys_clk);
            n++;
        end
        n_checks++;
        if (eng_cmd_valid !== 1'b1) begin
            n_err++;
            $display("FAIL tmo_issue: eng_cmd_valid=%b, expected 1", eng_cmd_valid);
        end
        req = '0;
        @(negedge sys_clk);
        eng_cmd_ready = 1'b1;
        @(negedge sys_clk);
        eng_cmd_ready = 1'b0;
`ifdef I2C_ARB_TIMEOUT_EN
        repeat (13) @(negedge sys_clk);
        n_checks++;
        if (eng_abort !== 1'b0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL tmo_early: abort=%b busy=%b at cycle 16, expected 0/1", eng_abort, busy);
        end
        @(negedge sys_clk);
        n_checks++;
        if (eng_abort !== 1'b1 || rsp_err !== 3'b001 || rsp_nack !== 3'b000 || eng_cmd_valid !== 1'b0) begin
            n_err++;
            $display("FAIL tmo_abort: abort=%b err=%b nack=%b valid=%b, expected 1/001/000/0",
                     eng_abort, rsp_err, rsp_nack, eng_cmd_valid);
        end
        @(negedge sys_clk);
        n_checks++;
        if (eng_abort !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL tmo_after: abort=%b busy=%b, expected 0/0", eng_abort, busy);
        end
`else
        repeat (40) @(negedge sys_clk);
        n_checks++;
        if (busy !== 1'b1 || eng_abort !== 1'b0 || rsp_done !== 3'b000) begin
            n_err++;
            $display("FAIL no_tmo_wait: busy=%b abort=%b done=%b, expected 1/0/000", busy, eng_abort, rsp_done);
        end
        eng_done = 1'b1;
        eng_ack  = 1'b1;
        @(negedge sys_clk);
        eng_done = 1'b0;
        eng_ack  = 1'b0;
        n_checks++;
        if (rsp_done !== 3'b001 || rsp_err !== 3'b000) begin
            n_err++;
            $display("FAIL no_tmo_done: done=%b err=%b, expected 001/000", rsp_done, rsp_err);
        end
        @(negedge sys_clk);
`endif
    endtask

    initial begin
        test_reset();
        test_single();
        test_nack();
        test_wrap();
        test_back_to_back();
        test_reset_mid();
        test_timeout();
        repeat (3) @(negedge sys_clk);
        n_checks++;
        if (gq.size() != 0 || rq.size() != 0) begin
            n_err++;
            $display("FAIL queues_drained: %0d grants and %0d responses outstanding, expected 0 and 0",
                     gq.size(), rq.size());
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
